// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB pipeline stage.
//  - default datapath widths
//  - RV64 load funct3 encodings
//  - stage occupancy encoding (the two valid bits: {skid_valid, main_valid})
//  - packed entry payload carried through the skid buffer
package mem_wb_stage_pkg;

    localparam int MW_XLEN   = 64;
    localparam int MW_PC_W   = 32;
    localparam int MW_REG_AW = 5;
    localparam int MW_MTR_W  = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Encoded so that bit 0 is main_valid and bit 1 is skid_valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    typedef struct packed {
        logic [MW_PC_W-1:0]   pc;
        logic [2:0]           funct3;
        logic [MW_MTR_W-1:0]  memtoreg;
        logic                 reg_wr;
        logic [MW_REG_AW-1:0] rd;
        logic [MW_XLEN-1:0]   alu_res;
        logic [MW_XLEN-1:0]   rdata;
    } mem_wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Handshake and payload bundle between the memory stage, the MEM->WB stage
// and writeback.
//  slave  : the MEM->WB stage (consumes in_*, produces out_* and in_ready)
//  master : the surrounding pipeline / testbench (drives in_*, out_ready)
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN   = MW_XLEN,
    parameter int PC_W   = MW_PC_W,
    parameter int REG_AW = MW_REG_AW,
    parameter int MTR_W  = MW_MTR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [2:0]        in_funct3;
    logic [MTR_W-1:0]  in_memtoreg;
    logic              in_reg_wr;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_alu_res;
    logic [XLEN-1:0]   in_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [2:0]        out_funct3;
    logic [MTR_W-1:0]  out_memtoreg;
    logic              out_reg_wr;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_alu_res;
    logic [XLEN-1:0]   out_rdata;
    logic [XLEN-1:0]   out_load_data;

    modport slave (
        input  in_valid, in_pc, in_funct3, in_memtoreg, in_reg_wr, in_rd,
               in_alu_res, in_rdata, out_ready,
        output in_ready, out_valid, out_pc, out_funct3, out_memtoreg,
               out_reg_wr, out_rd, out_alu_res, out_rdata, out_load_data
    );

    modport master (
        output in_valid, in_pc, in_funct3, in_memtoreg, in_reg_wr, in_rd,
               in_alu_res, in_rdata, out_ready,
        input  in_ready, out_valid, out_pc, out_funct3, out_memtoreg,
               out_reg_wr, out_rd, out_alu_res, out_rdata, out_load_data
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// RV64 load alignment and extension (purely combinational).
//  funct3    in   3   load width / signedness
//  off       in   3   byte offset (effective address [2:0])
//  rdata     in   64  raw doubleword from data memory
//  load_data out  64  value ready for the register file
// Misaligned low offset bits are simply dropped; the trap is raised upstream.
module mem_wb_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] rdata,
    output logic [63:0] load_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[2:1], 4'b0000} +: 16];
        word_v = rdata[{off[2], 5'b00000} +: 32];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{56{byte_v[7]}}, byte_v};
            F3_LH:   load_data = {{48{half_v[15]}}, half_v};
            F3_LW:   load_data = {{32{word_v[31]}}, word_v};
            F3_LBU:  load_data = {56'd0, byte_v};
            F3_LHU:  load_data = {48'd0, half_v};
            F3_LWU:  load_data = {32'd0, word_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake, 2-entry skid buffer,
// synchronous flush, RV64 load alignment on the output entry.
//  clk    in  clock, rising edge
//  rst    in  asynchronous active-high reset
//  flush  in  squash all held entries and the same-cycle input
//  bus    slave modport of mem_wb_stage_if (in_* / out_* handshake + payload)
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | nothing held, out_valid=0, in_ready=1
// ST_ONE   | main entry valid (driving out_*), skid empty
// ST_FULL  | main and skid valid, in_ready=0 until main retires
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    mem_wb_stage_if.slave   bus
);
    stage_state_e  state_q, state_d;
    mem_wb_entry_t main_q, skid_q, in_entry;
    logic          accept, retire;
    logic          main_ld, main_from_skid, skid_ld;

    // in_ready depends only on the skid valid flop, so there is no
    // combinational path from out_ready back upstream.
    assign bus.in_ready  = ~state_q[1];
    assign bus.out_valid = state_q[0];

    assign accept = bus.in_valid & bus.in_ready;
    assign retire = bus.out_valid & bus.out_ready;

    always_comb begin
        in_entry.pc       = bus.in_pc;
        in_entry.funct3   = bus.in_funct3;
        in_entry.memtoreg = bus.in_memtoreg;
        in_entry.reg_wr   = bus.in_reg_wr;
        in_entry.rd       = bus.in_rd;
        in_entry.alu_res  = bus.in_alu_res;
        in_entry.rdata    = bus.in_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            // A retire in this cycle still completes on the WB side; only
            // the held copies and the incoming entry are dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = ST_FULL;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        main_from_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload is not cleared by flush, only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_ld)             main_q <= in_entry;
            else if (main_from_skid) main_q <= skid_q;
            if (skid_ld)             skid_q <= in_entry;
        end
    end

    assign bus.out_pc       = main_q.pc;
    assign bus.out_funct3   = main_q.funct3;
    assign bus.out_memtoreg = main_q.memtoreg;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_alu_res  = main_q.alu_res;
    assign bus.out_rdata    = main_q.rdata;
    assign bus.out_reg_wr   = main_q.reg_wr & state_q[0] & (main_q.rd != '0);

    mem_wb_load_align u_align (
        .funct3    (main_q.funct3),
        .off       (main_q.alu_res[2:0]),
        .rdata     (main_q.rdata),
        .load_data (bus.out_load_data)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] retired[$];

    localparam logic [63:0] RD = 64'h8877_6655_4433_2211;

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) retired.push_back(bus.out_pc);
    end

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] addr;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [63:0] exp_load;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] rdata,
                         input logic wr, input logic [4:0] rd);
        bus.in_valid    = v;
        bus.in_pc       = pc;
        bus.in_funct3   = f3;
        bus.in_memtoreg = 3'd1;
        bus.in_alu_res  = alu;
        bus.in_rdata    = rdata;
        bus.in_reg_wr   = wr;
        bus.in_rd       = rd;
    endtask

    task automatic chk_retired(input string name, input int mark, input logic [31:0] exp[$]);
        chk({name, " count"}, 64'(retired.size() - mark), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (mark + i < retired.size())
                chk({name, " pc"}, 64'(retired[mark + i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int mark;
        logic [31:0] expq[$];

        vecs[0]  = '{F3_LB,  64'h1007, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
        vecs[1]  = '{F3_LB,  64'h1007, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF88, 1'b1};
        vecs[2]  = '{F3_LBU, 64'h1007, 1'b1, 5'd5, 64'h0000_0000_0000_0088, 1'b1};
        vecs[3]  = '{F3_LH,  64'h1002, 1'b0, 5'd5, 64'h0000_0000_0000_4433, 1'b0};
        vecs[4]  = '{F3_LW,  64'h1004, 1'b1, 5'd7, 64'hFFFF_FFFF_8877_6655, 1'b1};
        vecs[5]  = '{F3_LWU, 64'h1004, 1'b1, 5'd7, 64'h0000_0000_8877_6655, 1'b1};
        vecs[6]  = '{F3_LD,  64'h1000, 1'b1, 5'd1, RD,                      1'b1};
        vecs[7]  = '{F3_LHU, 64'h1006, 1'b1, 5'd2, 64'h0000_0000_0000_8877, 1'b1};
        vecs[8]  = '{F3_LH,  64'h1006, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_8877, 1'b1};
        vecs[9]  = '{F3_LB,  64'h1000, 1'b1, 5'd3, 64'h0000_0000_0000_0011, 1'b1};
        vecs[10] = '{F3_LW,  64'h1005, 1'b1, 5'd3, 64'hFFFF_FFFF_8877_6655, 1'b1};
        vecs[11] = '{3'b111, 64'h1003, 1'b1, 5'd3, RD,                      1'b1};
        vecs[12] = '{F3_LH,  64'h1003, 1'b1, 5'd3, 64'h0000_0000_0000_4433, 1'b1};

        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        bus.out_ready = 1'b0;

        // reset state
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst load_data", bus.out_load_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-transfer with FULL held
        drive(1'b1, 32'h500, F3_LD, 64'h55, RD, 1'b1, 5'd3);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 32'h504, F3_LD, 64'h66, RD, 1'b1, 5'd4);
        @(posedge clk); @(negedge clk);
        chk("full in_ready", 64'(bus.in_ready), 64'd0);
        chk("full out_reg_wr", 64'(bus.out_reg_wr), 64'd1);
        drive(1'b1, 32'h508, F3_LD, 64'h77, RD, 1'b1, 5'd4);
        bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst out_pc", 64'(bus.out_pc), 64'd0);
        chk("arst out_reg_wr", 64'(bus.out_reg_wr), 64'd0);
        chk("arst load_data", bus.out_load_data, 64'd0);
        mark = retired.size();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst hold out_valid", 64'(bus.out_valid), 64'd0);
        end
        rst = 1'b0;
        drive(1'b1, 32'h600, F3_LD, 64'h88, RD, 1'b1, 5'd6);
        #1 chk("post-rst pre-edge out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("post-rst out_valid", 64'(bus.out_valid), 64'd1);
        chk("post-rst out_pc", 64'(bus.out_pc), 64'h600);
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        @(posedge clk); @(negedge clk);
        expq = '{32'h600};
        chk_retired("reset retire", mark, expq);

        // streaming
        mark = retired.size();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), F3_LD, 64'(i), RD, 1'b1, 5'd8);
            chk("stream in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk); @(negedge clk);
            chk("stream out_valid", 64'(bus.out_valid), 64'd1);
            chk("stream out_pc", 64'(bus.out_pc), 64'(32'h100 + 32'(4 * i)));
        end
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        @(posedge clk); @(negedge clk);
        chk("stream drain out_valid", 64'(bus.out_valid), 64'd0);
        expq = '{32'h100, 32'h104, 32'h108, 32'h10C};
        chk_retired("stream", mark, expq);

        // backpressure
        mark = retired.size();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h200, F3_LD, 64'hAAA0, RD, 1'b1, 5'd9);
        @(posedge clk); @(negedge clk);
        chk("bp A out_pc", 64'(bus.out_pc), 64'h200);
        chk("bp A in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h204, F3_LD, 64'hBBB0, RD, 1'b1, 5'd9);
        @(posedge clk); @(negedge clk);
        chk("bp in_ready after B", 64'(bus.in_ready), 64'd0);
        chk("bp A held pc", 64'(bus.out_pc), 64'h200);
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        @(posedge clk); @(negedge clk);
        chk("bp A stable pc", 64'(bus.out_pc), 64'h200);
        chk("bp A stable alu", bus.out_alu_res, 64'hAAA0);
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp B out_pc", 64'(bus.out_pc), 64'h204);
        chk("bp B in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("bp drained", 64'(bus.out_valid), 64'd0);
        expq = '{32'h200, 32'h204};
        chk_retired("bp", mark, expq);

        // load alignment / write gating table
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), vecs[i].f3, vecs[i].addr, RD,
                  vecs[i].reg_wr, vecs[i].rd);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d load_data", i), bus.out_load_data, vecs[i].exp_load);
            chk($sformatf("vec%0d out_reg_wr", i), 64'(bus.out_reg_wr), 64'(vecs[i].exp_wr));
        end
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        @(posedge clk); @(negedge clk);

        // flush while FULL with a same-cycle input
        mark = retired.size();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h400, F3_LD, 64'h0, RD, 1'b1, 5'd1);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 32'h404, F3_LD, 64'h0, RD, 1'b1, 5'd1);
        @(posedge clk); @(negedge clk);
        chk("flush pre in_ready", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h408, F3_LD, 64'h0, RD, 1'b1, 5'd1);
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 1'b0, 5'd0);
        chk("flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush out_reg_wr", 64'(bus.out_reg_wr), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("post-flush out_valid", 64'(bus.out_valid), 64'd0);
        end
        expq = {};
        chk_retired("flush", mark, expq);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
